// File: rtl/router_dest_reader.sv
// Destination-side reader for one router output port.
// Pops the port FIFO, rebuilds header/payload/parity, checks parity and
// reports per-packet status and running packet/error counts.
module router_dest_reader #(
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    input  logic             soft_reset,
    output logic             read_enb,
    output logic             busy,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             pkt_abort,
    output logic [1:0]       pkt_addr,
    output logic [5:0]       pkt_len,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT    = 3'd1;
    localparam logic [2:0] HDR_RD  = 3'd2;
    localparam logic [2:0] HDR_CAP = 3'd3;
    localparam logic [2:0] BODY    = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    // With no settle time the header read follows IDLE directly, which keeps
    // the vld_out-to-first-read latency at WAIT_CYCLES+1 for every setting.
    localparam logic [2:0] START_ST = (WAIT_CYCLES == 0) ? HDR_RD : WAIT;

    logic [2:0] state, state_nxt;
    logic [4:0] wait_cnt;
    logic [6:0] remaining;   // reads still to issue (payload + parity)
    logic [5:0] cap_cnt;     // payload bytes captured so far
    logic [7:0] acc;         // running XOR of header and payload
    logic       rd_q;        // data_out holds a popped byte this cycle
    logic       in_pkt;
    logic       kill;
    logic       last_cap;

    assign in_pkt   = state inside {WAIT, HDR_RD, HDR_CAP, BODY};
    assign kill     = soft_reset && in_pkt;
    assign busy     = (state != IDLE);
    assign last_cap = (state == BODY) && rd_q && (cap_cnt == pkt_len);

    // FIFO pop request; soft_reset gates it in the same cycle
    always_comb begin
        read_enb = 1'b0;
        if (!soft_reset) begin
            case (state)
                HDR_RD:  read_enb = 1'b1;
                BODY:    read_enb = vld_out && (remaining != 7'd0);
                default: read_enb = 1'b0;
            endcase
        end
    end

    // Next-state selection; an in-flight soft_reset overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vld_out) state_nxt = START_ST;
            WAIT:    if (!vld_out) state_nxt = IDLE;
                     else if (wait_cnt == 5'd1) state_nxt = HDR_RD;
            HDR_RD:  state_nxt = HDR_CAP;
            HDR_CAP: state_nxt = BODY;
            BODY:    if (last_cap) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Packet datapath, status pulses and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt   <= '0;
            remaining  <= '0;
            cap_cnt    <= '0;
            acc        <= '0;
            rd_q       <= 1'b0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            pkt_abort  <= 1'b0;
            pkt_addr   <= '0;
            pkt_len    <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
        end else begin
            rd_q       <= read_enb;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            pkt_abort  <= 1'b0;
            if (kill) begin
                pkt_abort <= 1'b1;
                acc       <= '0;
                cap_cnt   <= '0;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: wait_cnt <= 5'(WAIT_CYCLES);
                    WAIT: if (vld_out) wait_cnt <= wait_cnt - 5'd1;
                    HDR_CAP: begin
                        pkt_addr  <= data_out[1:0];
                        pkt_len   <= data_out[7:2];
                        acc       <= data_out;
                        cap_cnt   <= '0;
                        remaining <= {1'b0, data_out[7:2]} + 7'd1;
                    end
                    BODY: begin
                        if (read_enb) remaining <= remaining - 7'd1;
                        if (rd_q) begin
                            if (cap_cnt == pkt_len) begin
                                // parity byte: compared, never folded in
                                pkt_done   <= 1'b1;
                                parity_err <= (data_out != acc);
                                acc        <= '0;
                            end else begin
                                acc     <= acc ^ data_out;
                                cap_cnt <= cap_cnt + 6'd1;
                            end
                        end
                    end
                    DONE: begin
                        pkt_count <= pkt_count + 1'b1;
                        if (parity_err && (err_count != '1))
                            err_count <= err_count + 1'b1;
                        cap_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: FIFO model on the read side, table of
// packets plus hand-written abort, idle soft_reset, async reset and
// counter wrap/saturate sequences. Expected results go through a scoreboard.
module tb_router_dest_reader;

    localparam int WAITC = 4;
    localparam int CW    = 2;

    logic          clock = 1'b0;
    logic          reset, vld_out, soft_reset;
    logic [7:0]    data_out;
    logic          read_enb, busy, pkt_done, parity_err, pkt_abort;
    logic [1:0]    pkt_addr;
    logic [5:0]    pkt_len;
    logic [CW-1:0] pkt_count, err_count;

    always #5 clock = ~clock;

    router_dest_reader #(.WAIT_CYCLES(WAITC), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
        .soft_reset(soft_reset), .read_enb(read_enb), .busy(busy),
        .pkt_done(pkt_done), .parity_err(parity_err), .pkt_abort(pkt_abort),
        .pkt_addr(pkt_addr), .pkt_len(pkt_len), .pkt_count(pkt_count),
        .err_count(err_count)
    );

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic [7:0] seed;
        logic       corrupt;
        int         stall_at;   // reads issued before vld_out is forced low
        int         stall_len;
        logic       exp_err;
    } vec_t;

    typedef struct {
        bit         abort;
        logic [1:0] addr;
        logic [5:0] len;
        logic       err;
        int         nrd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fifo[$];
    int errors = 0, checks = 0;
    int cyc = 0, nreads = 0, hold_cnt = 0, stall_at = 0, stall_len = 0, sr_at = 0;
    int rise_cyc, first_cyc;
    bit rd_pend = 0, sr_next = 0, flush_next = 0, lat_arm = 0;
    logic [CW-1:0] exp_pkt = '0, exp_err = '0;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: FIFO pop for last cycle's read, drive inputs, sample outputs.
    task automatic step();
        exp_t e;
        bit holding;
        @(negedge clock);
        if (rd_pend) data_out = (fifo.size() != 0) ? fifo.pop_front() : 8'h00;
        if (flush_next) begin fifo.delete(); flush_next = 0; end
        soft_reset = sr_next;
        if (sr_next) flush_next = 1;
        sr_next = 0;
        vld_out = (fifo.size() != 0) && (hold_cnt == 0);
        holding = (fifo.size() != 0) && (hold_cnt != 0);
        if (hold_cnt > 0) hold_cnt--;
        #1;
        rd_pend = read_enb;
        if (read_enb) nreads++;
        if (soft_reset) chk("rd_gate_soft_reset", read_enb, 0);
        if (holding)    chk("rd_gate_stall", read_enb, 0);
        if (!busy)      chk("rd_idle", read_enb, 0);
        if (lat_arm) begin
            if (vld_out && rise_cyc < 0) rise_cyc = cyc;
            if (read_enb && first_cyc < 0) first_cyc = cyc;
        end
        if (parity_err) chk("err_without_done", pkt_done, 1);
        if (pkt_done || pkt_abort) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_status: done=%0b abort=%0b with nothing expected", pkt_done, pkt_abort);
            end else begin
                e = sb.pop_front();
                chk("kind_abort", pkt_abort, e.abort);
                chk("kind_done", pkt_done, !e.abort);
                if (!e.abort) begin
                    chk("pkt_addr", pkt_addr, e.addr);
                    chk("pkt_len", pkt_len, e.len);
                    chk("parity_err", parity_err, e.err);
                    chk("read_total", nreads, e.nrd);
                end
            end
            nreads = 0;
        end
        if (stall_at > 0 && read_enb && nreads == stall_at) begin
            hold_cnt = stall_len; stall_at = 0;
        end
        if (sr_at > 0 && read_enb && nreads == sr_at) begin
            sr_next = 1; sr_at = 0;
        end
        cyc++;
    endtask

    task automatic load_pkt(input vec_t v, input int sr_after);
        logic [7:0] h, p, b;
        exp_t e;
        h = {v.len, v.addr};
        p = h;
        fifo.push_back(h);
        for (int i = 0; i < int'(v.len); i++) begin
            b = v.seed + 8'(i * 17);
            fifo.push_back(b);
            p ^= b;
        end
        if (v.corrupt) p ^= 8'h01;
        fifo.push_back(p);
        e.abort = (sr_after > 0);
        e.addr  = v.addr;
        e.len   = v.len;
        e.err   = v.exp_err;
        e.nrd   = int'(v.len) + 2;
        sb.push_back(e);
    endtask

    task automatic run_pkt(input vec_t v, input int sr_after);
        load_pkt(v, sr_after);
        stall_at  = v.stall_at;
        stall_len = v.stall_len;
        sr_at     = sr_after;
        lat_arm   = 1; rise_cyc = -1; first_cyc = -1;
        for (int t = 0; t < 400 && sb.size() != 0; t++) step();
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: %0d expected results still pending", sb.size());
            sb.delete();
        end
        step(); step();
        lat_arm = 0;
        if (sr_after == 0) begin
            exp_pkt = exp_pkt + 1'b1;
            if (v.exp_err && exp_err != '1) exp_err = exp_err + 1'b1;
        end
        chk("pkt_count", pkt_count, exp_pkt);
        chk("err_count", err_count, exp_err);
        chk("busy_after", busy, 0);
        chk("latency", first_cyc - rise_cyc, WAITC + 1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        fifo.delete(); sb.delete();
        nreads = 0; rd_pend = 0; hold_cnt = 0; sr_next = 0; flush_next = 0;
        stall_at = 0; sr_at = 0;
        vld_out = 1'b0; soft_reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_read_enb", read_enb, 0);
        chk("rst_pulses", {pkt_done, parity_err, pkt_abort}, 0);
        chk("rst_hdr", {pkt_len, pkt_addr}, 0);
        chk("rst_counts", {pkt_count, err_count}, 0);
        @(negedge clock);
        reset = 1'b0;
        exp_pkt = '0; exp_err = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset = 1'b0; vld_out = 1'b0; soft_reset = 1'b0; data_out = 8'h00;
        //          addr   len    seed   bad  stall  slen  exp_err
        tbl[0] = '{2'd2, 6'd3,  8'h11, 1'b0, 0, 0, 1'b0};
        tbl[1] = '{2'd2, 6'd3,  8'h11, 1'b1, 0, 0, 1'b1};
        tbl[2] = '{2'd2, 6'd0,  8'h11, 1'b0, 0, 0, 1'b0};
        tbl[3] = '{2'd1, 6'd4,  8'hA5, 1'b0, 3, 5, 1'b0};
        tbl[4] = '{2'd3, 6'd63, 8'h3C, 1'b0, 0, 0, 1'b0};
        tbl[5] = '{2'd0, 6'd1,  8'hF0, 1'b1, 0, 0, 1'b1};

        do_reset();
        for (int i = 0; i < 6; i++) run_pkt(tbl[i], 0);

        // soft_reset after header + one payload byte, then a clean packet
        run_pkt(tbl[0], 2);
        run_pkt(tbl[2], 0);

        // soft_reset while idle must not produce an abort
        sr_next = 1;
        for (int i = 0; i < 3; i++) step();
        chk("idle_sr_busy", busy, 0);

        // async reset in the middle of a packet, then recovery
        v = '{2'd1, 6'd5, 8'h07, 1'b0, 0, 0, 1'b0};
        load_pkt(v, 0);
        for (int i = 0; i < 9; i++) step();
        chk("mid_busy", busy, 1);
        do_reset();
        run_pkt(tbl[0], 0);

        // counter wrap and saturation from a fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) run_pkt(tbl[0], 0);
        for (int i = 0; i < 5; i++) run_pkt(tbl[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
